conv2d_stream_engine: RTL

// Parametrised multi-channel 2-D convolution engine, successor to the single-channel block.

---
 rtl/conv2d_stream_engine_pkg.sv | 23 ++
 rtl/conv2d_stream_engine_if.sv | 26 ++
 rtl/conv2d_stream_engine_mac_sat.sv | 54 +++++
 rtl/conv2d_stream_engine.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/conv2d_stream_engine_pkg.sv
// Shared types and elaboration helpers for the 2-D convolution engine.
// Pooling and FC blocks built on the same MAC can import this package too.
package conv2d_stream_engine_pkg;

  typedef enum logic [2:0] {IDLE, FETCH, DRAIN, WRITE, DONE} convState;

  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r++;
      x = x >> 1;
    end
    return r;
  endfunction

  function automatic int outDim(input int img, input int k, input int s);
    return (img - k) / s + 1;
  endfunction

endpackage

// File: rtl/conv2d_stream_engine_if.sv
// RAM-side bundle: image read port, kernel read port and output write port.
// Image and kernel RAMs share one read enable and have 1-cycle read latency.
interface conv2d_stream_engine_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 9,
  parameter int COEF_W = 4
);
  logic        [ADDR_W-1:0] img_addr;
  logic                     img_rd;
  logic signed [DATA_W-1:0] img_data;
  logic        [ADDR_W-1:0] coef_addr;
  logic signed [COEF_W-1:0] coef_data;
  logic        [ADDR_W-1:0] out_addr;
  logic                     out_we;
  logic signed [DATA_W-1:0] out_data;

  modport master (
    output img_addr, img_rd, coef_addr, out_addr, out_we, out_data,
    input  img_data, coef_data
  );

  modport slave (
    input  img_addr, img_rd, coef_addr, out_addr, out_we, out_data,
    output img_data, coef_data
  );
endinterface

// File: rtl/conv2d_stream_engine_mac_sat.sv
// Signed multiply-accumulate with bias load, arithmetic shift, optional ReLU
// and saturation to the output width; result is captured on request.
module conv2d_stream_engine_mac_sat #(
  parameter int DATA_W = 9,
  parameter int COEF_W = 4,
  parameter int ACC_W  = 24
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en,
  input  logic                     load,
  input  logic                     capture,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [COEF_W-1:0] b,
  input  logic signed [ACC_W-1:0]  bias,
  input  logic        [4:0]        shift,
  input  logic                     reluEn,
  output logic signed [DATA_W-1:0] result
);
  localparam int PROD_W = DATA_W + COEF_W;
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (DATA_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(1 << (DATA_W - 1)));

  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  prodExt;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  accNext;
  logic signed [ACC_W-1:0]  shifted;
  logic signed [DATA_W-1:0] clipped;

  assign prod    = a * b;
  assign prodExt = {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};

  // The output is taken from accNext so the final data beat is included.
  always_comb begin
    accNext = acc;
    if (en) accNext = load ? bias + prodExt : acc + prodExt;
    shifted = accNext >>> shift;
    if (reluEn && shifted[ACC_W-1]) shifted = '0;
    clipped = DATA_W'(shifted);
    if (shifted > SAT_MAX)      clipped = DATA_W'(SAT_MAX);
    else if (shifted < SAT_MIN) clipped = DATA_W'(SAT_MIN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc    <= '0;
      result <= '0;
    end else begin
      acc <= accNext;
      if (capture) result <= clipped;
    end
  end
endmodule

// File: rtl/conv2d_stream_engine.sv
// Multi-channel 2-D convolution engine: walks every valid output pixel, streams
// CH*K*K taps through the MAC and writes one saturated result per pixel.
//
// state | meaning
// IDLE  | waiting for start; config captured when start is accepted
// FETCH | one tap read per cycle (kx fastest, then ky, then c)
// DRAIN | last data beat absorbed, result registered
// WRITE | out_we for one cycle, advance pixel (ox fastest, then oy)
// DONE  | done pulse, back to IDLE
module conv2d_stream_engine
  import conv2d_stream_engine_pkg::*;
#(
  parameter int IMG_ROWS = 15,
  parameter int IMG_COLS = 14,
  parameter int K        = 3,
  parameter int STRIDE   = 1,
  parameter int CH       = 1,
  parameter int DATA_W   = 9,
  parameter int COEF_W   = 4,
  parameter int ACC_W    = 24,
  parameter int ADDR_W   = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    relu_en,
  input  logic [4:0]              shift,
  input  logic signed [ACC_W-1:0] bias,
  output logic                    busy,
  output logic                    done,
  conv2d_stream_engine_if.master  mem
);
  localparam int OUT_R = outDim(IMG_ROWS, K, STRIDE);
  localparam int OUT_C = outDim(IMG_COLS, K, STRIDE);

  localparam logic [ADDR_W-1:0] ONE     = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_K     = ADDR_W'(K);
  localparam logic [ADDR_W-1:0] A_S     = ADDR_W'(STRIDE);
  localparam logic [ADDR_W-1:0] A_COLS  = ADDR_W'(IMG_COLS);
  localparam logic [ADDR_W-1:0] A_PLANE = ADDR_W'(IMG_ROWS * IMG_COLS);
  localparam logic [ADDR_W-1:0] A_OUTC  = ADDR_W'(OUT_C);
  localparam logic [ADDR_W-1:0] LAST_K  = ADDR_W'(K - 1);
  localparam logic [ADDR_W-1:0] LAST_CH = ADDR_W'(CH - 1);
  localparam logic [ADDR_W-1:0] LAST_OX = ADDR_W'(OUT_C - 1);
  localparam logic [ADDR_W-1:0] LAST_OY = ADDR_W'(OUT_R - 1);

  convState state, stateNext;
  logic [ADDR_W-1:0] kx, ky, c, ox, oy;
  logic lastTap, lastPix, firstTap;
  logic imgRd, capture, outWe;
  logic beatValid, beatFirst;
  logic reluCfg;
  logic [4:0] shiftCfg;
  logic signed [ACC_W-1:0] biasCfg;

  assign lastTap  = (kx == LAST_K) && (ky == LAST_K) && (c == LAST_CH);
  assign firstTap = (kx == '0) && (ky == '0) && (c == '0);
  assign lastPix  = (ox == LAST_OX) && (oy == LAST_OY);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    imgRd     = 1'b0;
    capture   = 1'b0;
    outWe     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE:  if (start) stateNext = FETCH;
      FETCH: begin
        busy  = 1'b1;
        imgRd = 1'b1;
        if (lastTap) stateNext = DRAIN;
      end
      DRAIN: begin
        busy      = 1'b1;
        capture   = 1'b1;
        stateNext = WRITE;
      end
      WRITE: begin
        busy      = 1'b1;
        outWe     = 1'b1;
        stateNext = lastPix ? DONE : FETCH;
      end
      DONE: begin
        done      = 1'b1;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      kx <= '0; ky <= '0; c <= '0; ox <= '0; oy <= '0;
      beatValid <= 1'b0;
      beatFirst <= 1'b0;
      reluCfg   <= 1'b0;
      shiftCfg  <= '0;
      biasCfg   <= '0;
    end else begin
      if (state == IDLE && start) begin
        reluCfg  <= relu_en;
        shiftCfg <= shift;
        biasCfg  <= bias;
        kx <= '0; ky <= '0; c <= '0; ox <= '0; oy <= '0;
      end
      if (state == FETCH) begin
        if (kx == LAST_K) begin
          kx <= '0;
          if (ky == LAST_K) begin
            ky <= '0;
            c  <= (c == LAST_CH) ? '0 : c + ONE;
          end else ky <= ky + ONE;
        end else kx <= kx + ONE;
      end
      if (state == WRITE) begin
        if (ox == LAST_OX) begin
          ox <= '0;
          oy <= (oy == LAST_OY) ? '0 : oy + ONE;
        end else ox <= ox + ONE;
      end
      // Data returns one cycle after the read, so the tap tags are delayed to match.
      beatValid <= imgRd;
      beatFirst <= imgRd && firstTap;
    end
  end

  assign mem.img_rd    = imgRd;
  assign mem.out_we    = outWe;
  assign mem.img_addr  = c * A_PLANE + (oy * A_S + ky) * A_COLS + ox * A_S + kx;
  assign mem.coef_addr = (c * A_K + ky) * A_K + kx;
  assign mem.out_addr  = oy * A_OUTC + ox;

  conv2d_stream_engine_mac_sat #(
    .DATA_W(DATA_W),
    .COEF_W(COEF_W),
    .ACC_W (ACC_W)
  ) uMac (
    .clk    (clk),
    .reset  (reset),
    .en     (beatValid),
    .load   (beatFirst),
    .capture(capture),
    .a      (mem.img_data),
    .b      (mem.coef_data),
    .bias   (biasCfg),
    .shift  (shiftCfg),
    .reluEn (reluCfg),
    .result (mem.out_data)
  );
endmodule
